uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_arb_pkg.sv | 21 ++
 rtl/uart_arb_rr_pick.sv | 27 ++
 rtl/uart_tx_arbiter.sv | 151 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types and defaults for the rs232c transmit arbiter
package uart_arb_pkg;

  // Arbiter sequencing: pick, strobe, wait for rs232c to start, wait for it to finish
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

  localparam int N_REQ_DEF    = 4;
  localparam int BUSY_TMO_DEF = 15;

  // Wide enough for up to 8 requesters
  localparam int GRANT_W = 3;

  // Timeout counter covers BUSY_TMO up to 255
  localparam int TMO_CNT_W = 8;

endpackage

// File: rtl/uart_arb_rr_pick.sv
// rtl/uart_arb_rr_pick.sv - combinational round-robin picker starting after last_grant
module uart_arb_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0]   req,
  input  logic [GRANT_W-1:0] last_grant,
  output logic [GRANT_W-1:0] winner,
  output logic               valid
);

  // Scan distances from farthest to nearest so the nearest set bit after last_grant wins
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (req[j] && ((int'(last_grant) + k == j) || (int'(last_grant) + k == j + N_REQ))) begin
          winner = j[GRANT_W-1:0];
          valid  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - shares one rs232c transmitter among N_REQ requesters; UART_ARB_LOCK_EN adds req_lock
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int BUSY_TMO = BUSY_TMO_DEF
) (
  input  logic                 CLK,
  input  logic                 RESETB,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ*8-1:0]   req_data,
`ifdef UART_ARB_LOCK_EN
  input  logic [N_REQ-1:0]     req_lock,
`endif
  output logic [N_REQ-1:0]     req_ack,
  output logic [7:0]           TX_DATA,
  output logic                 TX_DATA_EN,
  input  logic                 TX_BUSY,
  output logic [GRANT_W-1:0]   grant_id,
  output logic                 arb_busy,
  output logic                 tmo_err
);

  arb_state_t             state;
  arb_state_t             state_next;
  logic [GRANT_W-1:0]     last_grant;
  logic [TMO_CNT_W-1:0]   tmo_cnt;
  logic [GRANT_W-1:0]     rr_winner;
  logic                   rr_valid;
  logic [GRANT_W-1:0]     winner;
  logic [7:0]             sel_data;
  logic                   grant_now;
  logic                   tmo_hit;

  uart_arb_rr_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .req       (req),
    .last_grant(last_grant),
    .winner    (rr_winner),
    .valid     (rr_valid)
  );

`ifdef UART_ARB_LOCK_EN
  logic lock_hold;
  logic last_req;
  logic lock_now;

  // Request and lock bits of the requester most recently granted
  always_comb begin
    last_req = 1'b0;
    lock_now = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (last_grant == i[GRANT_W-1:0]) last_req = req[i];
      if (grant_id == i[GRANT_W-1:0]) lock_now = req_lock[i];
    end
  end

  // A lock captured at the previous ack keeps the bus with that requester while it still asks
  always_comb begin
    winner = rr_winner;
    if (lock_hold && last_req) winner = last_grant;
  end
`else
  assign winner = rr_winner;
`endif

  // A lock hit implies some req bit is set, so the picker's valid covers both paths
  assign grant_now = rr_valid && !TX_BUSY;
  assign tmo_hit   = (tmo_cnt == TMO_CNT_W'(BUSY_TMO - 1));

  // Byte of the chosen requester
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner == i[GRANT_W-1:0]) sel_data = req_data[i*8 +: 8];
    end
  end

  // State register
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) state <= IDLE;
    else         state <= state_next;
  end

  // Next state plus decoded strobe, ack and busy outputs
  always_comb begin
    state_next = state;
    TX_DATA_EN = 1'b0;
    req_ack    = '0;
    arb_busy   = (state != IDLE);
    case (state)
      IDLE: begin
        if (grant_now) state_next = ISSUE;
      end
      ISSUE: begin
        TX_DATA_EN = 1'b1;
        for (int i = 0; i < N_REQ; i++) begin
          if (grant_id == i[GRANT_W-1:0]) req_ack[i] = 1'b1;
        end
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (TX_BUSY)      state_next = WAIT_DONE;
        else if (tmo_hit) state_next = IDLE;
      end
      WAIT_DONE: begin
        if (!TX_BUSY) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Grant bookkeeping, latched byte, timeout counter and sticky error
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      TX_DATA    <= '0;
      grant_id   <= '0;
      last_grant <= GRANT_W'(N_REQ - 1);
      tmo_cnt    <= '0;
      tmo_err    <= 1'b0;
`ifdef UART_ARB_LOCK_EN
      lock_hold  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_now) begin
            TX_DATA  <= sel_data;
            grant_id <= winner;
          end
        end
        ISSUE: begin
          last_grant <= grant_id;
          tmo_cnt    <= '0;
`ifdef UART_ARB_LOCK_EN
          lock_hold  <= lock_now;
`endif
        end
        WAIT_BUSY: begin
          if (!TX_BUSY) begin
            if (tmo_hit) tmo_err <= 1'b1;
            else         tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with a simple rs232c busy model
module tb_uart_tx_arbiter;

  localparam int NR      = 4;
  localparam int TMO     = 15;
  localparam int BIT_END = 156;
  localparam int FRAME   = 10 * (BIT_END + 1);

  logic              CLK = 1'b0;
  logic              RESETB = 1'b0;
  logic [NR-1:0]     req = '0;
  logic [NR*8-1:0]   req_data = '0;
  logic [NR-1:0]     req_ack;
  logic [7:0]        TX_DATA;
  logic              TX_DATA_EN;
  logic              TX_BUSY;
  logic [2:0]        grant_id;
  logic              arb_busy;
  logic              tmo_err;
`ifdef UART_ARB_LOCK_EN
  logic [NR-1:0]     req_lock = '0;
`endif

  logic model_busy = 1'b0;
  logic model_en = 1'b1;
  int   model_cnt = 0;
  assign TX_BUSY = model_busy;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [2:0] id;
    logic [7:0] data;
  } exp_t;

  typedef struct packed {
    logic [2:0]    gid;
    logic [7:0]    data;
    logic [NR-1:0] ack;
  } obs_t;

  exp_t exp_q[$];
  obs_t obs_q[$];

  uart_tx_arbiter #(.N_REQ(NR), .BUSY_TMO(TMO)) dut (
    .CLK       (CLK),
    .RESETB    (RESETB),
    .req       (req),
    .req_data  (req_data),
`ifdef UART_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .req_ack   (req_ack),
    .TX_DATA   (TX_DATA),
    .TX_DATA_EN(TX_DATA_EN),
    .TX_BUSY   (TX_BUSY),
    .grant_id  (grant_id),
    .arb_busy  (arb_busy),
    .tmo_err   (tmo_err)
  );

  always #5 CLK = ~CLK;

  // rs232c stand-in: busy for one frame starting the cycle after a strobe; ignores RESETB
  always @(posedge CLK) begin
    if (model_busy) begin
      if (model_cnt == 0) model_busy <= 1'b0;
      else                model_cnt  <= model_cnt - 1;
    end else if (TX_DATA_EN && model_en) begin
      model_busy <= 1'b1;
      model_cnt  <= FRAME - 1;
    end
  end

  // Capture every strobe for the scoreboard
  always @(negedge CLK) begin
    if (TX_DATA_EN) obs_q.push_back({grant_id, TX_DATA, req_ack});
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic wait_obs(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (obs_q.size() > 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int c = 0; c < budget; c++) begin
      tick();
      if (!TX_BUSY && !arb_busy) break;
    end
  endtask

  task automatic apply_reset();
    RESETB = 1'b0;
    tick();
    tick();
    RESETB = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_cmp++; if (TX_DATA !== 8'h00)    begin n_err++; $display("FAIL reset_tx_data: got %h need 00", TX_DATA); end
    n_cmp++; if (TX_DATA_EN !== 1'b0)  begin n_err++; $display("FAIL reset_tx_en: got %b need 0", TX_DATA_EN); end
    n_cmp++; if (req_ack !== '0)       begin n_err++; $display("FAIL reset_ack: got %b need 0", req_ack); end
    n_cmp++; if (grant_id !== 3'd0)    begin n_err++; $display("FAIL reset_grant_id: got %0d need 0", grant_id); end
    n_cmp++; if (arb_busy !== 1'b0)    begin n_err++; $display("FAIL reset_arb_busy: got %b need 0", arb_busy); end
    n_cmp++; if (tmo_err !== 1'b0)     begin n_err++; $display("FAIL reset_tmo_err: got %b need 0", tmo_err); end
    RESETB = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bit ok;
    obs_t o;
    exp_t e;
    logic [NR-1:0] oh;
    int c;
    req_data[7:0] = 8'h41;
    req = 4'b0001;
    exp_q.push_back({3'd0, 8'h41});
    wait_obs(100, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL single_strobe: no strobe seen, need one"); end
    else begin
      req = '0;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      oh = '0; oh[e.id] = 1'b1;
      n_cmp++; if (o.data !== e.data) begin n_err++; $display("FAIL single_data: got %h need %h", o.data, e.data); end
      n_cmp++; if (o.ack !== oh)      begin n_err++; $display("FAIL single_ack: got %b need %b", o.ack, oh); end
    end
    c = 0;
    while (!TX_BUSY && c < 20) begin tick(); c++; end
    c = 0;
    while (TX_BUSY && c < FRAME + 20) begin tick(); c++; end
    n_cmp++; if (arb_busy !== 1'b1) begin n_err++; $display("FAIL single_busy_hold: got %b need 1", arb_busy); end
    tick();
    n_cmp++; if (arb_busy !== 1'b0) begin n_err++; $display("FAIL single_busy_drop: got %b need 0", arb_busy); end
    n_cmp++; if (obs_q.size() !== 0) begin n_err++; $display("FAIL single_count: got %0d extra strobes need 0", obs_q.size()); end
  endtask

  task automatic test_round_robin();
    bit ok;
    obs_t o;
    exp_t e;
    logic [NR-1:0] oh;
    apply_reset();
    req_data = {8'h33, 8'h32, 8'h31, 8'h30};
    for (int k = 0; k < 5; k++) exp_q.push_back({3'(k % NR), 8'(8'h30 + (k % NR))});
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_obs(2 * FRAME, ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL rr_strobe%0d: no strobe seen, need one", k); break; end
      if (k == 4) req = '0;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      oh = '0; oh[e.id] = 1'b1;
      n_cmp++; if (o.data !== e.data) begin n_err++; $display("FAIL rr_data%0d: got %h need %h", k, o.data, e.data); end
      n_cmp++; if (o.ack !== oh)      begin n_err++; $display("FAIL rr_ack%0d: got %b need %b", k, o.ack, oh); end
      n_cmp++; if (o.gid !== e.id)    begin n_err++; $display("FAIL rr_gid%0d: got %0d need %0d", k, o.gid, e.id); end
    end
    req = '0;
    exp_q.delete();
    wait_idle(2 * FRAME);
  endtask

  task automatic test_timeout();
    bit ok;
    bit done;
    int cyc;
    obs_t o;
    exp_t e;
    model_en = 1'b0;
    req_data[15:8] = 8'h55;
    req = 4'b0010;
    exp_q.push_back({3'd1, 8'h55});
    wait_obs(100, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL tmo_strobe1: no strobe seen, need one"); end
    else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_cmp++; if (o.data !== e.data) begin n_err++; $display("FAIL tmo_data1: got %h need %h", o.data, e.data); end
    end
    cyc = 0; done = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (tmo_err) begin done = 1'b1; break; end
      cyc++;
    end
    n_cmp++; if (!done || cyc != TMO) begin n_err++; $display("FAIL tmo_cycles: got %0d (seen=%0d) need %0d", cyc, done, TMO); end
    n_cmp++; if (arb_busy !== 1'b0)   begin n_err++; $display("FAIL tmo_idle: arb_busy got %b need 0", arb_busy); end
    exp_q.push_back({3'd1, 8'h55});
    wait_obs(10, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL tmo_strobe2: no strobe seen, need one"); end
    else begin
      req = '0;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_cmp++; if (o.gid !== e.id) begin n_err++; $display("FAIL tmo_gid2: got %0d need %0d", o.gid, e.id); end
    end
    req = '0;
    exp_q.delete();
    for (int c = 0; c < TMO + 5; c++) tick();
    n_cmp++; if (tmo_err !== 1'b1) begin n_err++; $display("FAIL tmo_sticky: got %b need 1", tmo_err); end
    model_en = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    bit early;
    int c;
    obs_t o;
    exp_t e;
    req_data[23:16] = 8'h77;
    req = 4'b0100;
    wait_obs(100, ok);
    req = '0;
    obs_q.delete();
    for (int k = 0; k < 5; k++) tick();
    n_cmp++; if (!(arb_busy === 1'b1 && TX_BUSY === 1'b1)) begin n_err++; $display("FAIL mid_pre: busy=%b tx_busy=%b need 1/1", arb_busy, TX_BUSY); end
    RESETB = 1'b0;
    #1;
    n_cmp++; if (arb_busy !== 1'b0)   begin n_err++; $display("FAIL mid_arb_busy: got %b need 0", arb_busy); end
    n_cmp++; if (tmo_err !== 1'b0)    begin n_err++; $display("FAIL mid_tmo_err: got %b need 0", tmo_err); end
    n_cmp++; if (TX_DATA !== 8'h00)   begin n_err++; $display("FAIL mid_tx_data: got %h need 00", TX_DATA); end
    n_cmp++; if (grant_id !== 3'd0)   begin n_err++; $display("FAIL mid_grant_id: got %0d need 0", grant_id); end
    n_cmp++; if (TX_DATA_EN !== 1'b0 || req_ack !== '0) begin n_err++; $display("FAIL mid_strobe: en=%b ack=%b need 0/0", TX_DATA_EN, req_ack); end
    tick();
    RESETB = 1'b1;
    req_data[7:0] = 8'h10;
    req = 4'b0101;
    exp_q.push_back({3'd0, 8'h10});
    early = 1'b0;
    c = 0;
    while (TX_BUSY && c < 2 * FRAME) begin
      tick();
      c++;
      if (TX_BUSY && arb_busy) early = 1'b1;
    end
    n_cmp++; if (early !== 1'b0) begin n_err++; $display("FAIL mid_grant_while_busy: got %b need 0", early); end
    wait_obs(100, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL mid_strobe_after: no strobe seen, need one"); end
    else begin
      req = '0;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_cmp++; if (o.gid !== e.id)    begin n_err++; $display("FAIL mid_first_gid: got %0d need %0d", o.gid, e.id); end
      n_cmp++; if (o.data !== e.data) begin n_err++; $display("FAIL mid_first_data: got %h need %h", o.data, e.data); end
    end
    req = '0;
    exp_q.delete();
    wait_idle(2 * FRAME);
  endtask

`ifdef UART_ARB_LOCK_EN
  task automatic test_lock();
    bit ok;
    obs_t o;
    exp_t e;
    apply_reset();
    req_data[15:0] = {8'hA1, 8'hA0};
    req_lock = 4'b0001;
    req = 4'b0011;
    exp_q.push_back({3'd0, 8'hA0});
    exp_q.push_back({3'd0, 8'hA0});
    exp_q.push_back({3'd0, 8'hA0});
    exp_q.push_back({3'd1, 8'hA1});
    for (int k = 0; k < 4; k++) begin
      wait_obs(2 * FRAME, ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL lock_strobe%0d: no strobe seen, need one", k); break; end
      if (k == 2) req_lock = '0;
      if (k == 3) req = '0;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_cmp++; if (o.gid !== e.id) begin n_err++; $display("FAIL lock_gid%0d: got %0d need %0d", k, o.gid, e.id); end
    end
    req = '0;
    exp_q.delete();
    wait_idle(2 * FRAME);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_reset_mid_frame();
`ifdef UART_ARB_LOCK_EN
    test_lock();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
